// File: rtl/lcd_dma_fetch_engine.sv
`default_nettype none
// ============================================================================
// Module   : lcd_dma_fetch_engine
// Purpose  : Bus-master burst fetch stage feeding the LCD DMA FIFO. Reads the
//            frame buffer in 4/8-word bursts, either as one linear panel or
//            alternating between upper and lower panel buffers.
// Options  : LCD_DMA_PERF_EN adds the stall_cnt output (REQ cycles without
//            a grant, saturating, cleared by fp_pulse).
// Revision : 1.0 - initial release
// ============================================================================
module lcd_dma_fetch_engine #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              dual_panel,
  input  logic              burst_sel,
  input  logic [ADDR_W-1:0] upbase,
  input  logic [ADDR_W-1:0] lpbase,
  input  logic [CNT_W-1:0]  frame_words,
  input  logic              dma_req,
  input  logic              fifofull,
  input  logic              fp_pulse,
  output logic              m_req,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_len,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rlast,
  output logic              fifo_push,
  output logic [DATA_W-1:0] fifo_data,
  output logic              busy,
  output logic              frame_done
`ifdef LCD_DMA_PERF_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  // Clears the byte-lane bits so the panel pointers stay word aligned.
  localparam logic [ADDR_W-1:0] C_ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t              state_q;
  logic [ADDR_W-1:0]   up_ptr_q, lp_ptr_q;
  logic [CNT_W-1:0]    up_rem_q, lp_rem_q;
  logic                sel_q;       // 0 = upper panel, 1 = lower panel
  logic                fp_pend_q;   // frame pulse seen while a burst was in flight
  logic                m_req_q;
  logic [ADDR_W-1:0]   m_addr_q;
  logic [3:0]          m_len_q;
  logic                fifo_push_q;
  logic [DATA_W-1:0]   fifo_data_q;
  logic                frame_done_q;

  logic                eff_sel;
  logic [CNT_W-1:0]    sel_rem;
  logic [ADDR_W-1:0]   sel_ptr;
  logic [3:0]          max_len;
  logic [3:0]          burst_len;
  logic                all_done;
  logic                do_reload;
  logic [ADDR_W-1:0]   ptr_step;
  logic [CNT_W-1:0]    rem_step;

  // Panel choice for the next burst: empty panels are skipped in dual mode.
  always_comb begin
    eff_sel = 1'b0;
    if (dual_panel) begin
      if (sel_q) eff_sel = (lp_rem_q == '0) ? 1'b0 : 1'b1;
      else       eff_sel = (up_rem_q == '0) ? 1'b1 : 1'b0;
    end
    sel_rem   = eff_sel ? lp_rem_q : up_rem_q;
    sel_ptr   = eff_sel ? lp_ptr_q : up_ptr_q;
    max_len   = burst_sel ? 4'd8 : 4'd4;
    burst_len = (sel_rem < {{(CNT_W-4){1'b0}}, max_len}) ? sel_rem[3:0] : max_len;
    all_done  = dual_panel ? ((up_rem_q == '0) && (lp_rem_q == '0)) : (up_rem_q == '0);
    ptr_step  = {{(ADDR_W-6){1'b0}}, m_len_q, 2'b00};
    rem_step  = {{(CNT_W-4){1'b0}}, m_len_q};
    // Frame restart applies immediately when idle, or as a burst finishes.
    do_reload = (fp_pulse && ((state_q == ST_IDLE) || (state_q == ST_WAIT))) ||
                ((state_q == ST_DATA) && m_rvalid && m_rlast && (fp_pend_q || fp_pulse));
  end

  // Fetch FSM with registered bus, FIFO and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      up_ptr_q     <= '0;
      lp_ptr_q     <= '0;
      up_rem_q     <= '0;
      lp_rem_q     <= '0;
      sel_q        <= 1'b0;
      fp_pend_q    <= 1'b0;
      m_req_q      <= 1'b0;
      m_addr_q     <= '0;
      m_len_q      <= '0;
      fifo_push_q  <= 1'b0;
      fifo_data_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      fifo_push_q  <= (state_q == ST_DATA) && m_rvalid;
      if ((state_q == ST_DATA) && m_rvalid) fifo_data_q <= m_rdata;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (all_done) frame_done_q <= 1'b1;
          if (!fp_pulse) begin
            if (all_done) begin
              state_q <= ST_WAIT;
            end else if (enable && dma_req && !fifofull && (sel_rem != '0)) begin
              state_q  <= ST_REQ;
              m_req_q  <= 1'b1;
              m_addr_q <= sel_ptr;
              m_len_q  <= burst_len;
              sel_q    <= eff_sel;
            end
          end
        end
        ST_REQ: begin
          if (fp_pulse) fp_pend_q <= 1'b1;
          if (m_gnt) begin
            m_req_q <= 1'b0;
            state_q <= ST_DATA;
            if (sel_q) begin
              lp_ptr_q <= lp_ptr_q + ptr_step;
              lp_rem_q <= lp_rem_q - rem_step;
            end else begin
              up_ptr_q <= up_ptr_q + ptr_step;
              up_rem_q <= up_rem_q - rem_step;
            end
          end
        end
        ST_DATA: begin
          if (fp_pulse) fp_pend_q <= 1'b1;
          if (m_rvalid && m_rlast) begin
            state_q <= ST_IDLE;
            sel_q   <= dual_panel & ~sel_q;
          end
        end
        ST_WAIT: begin
          if (fp_pulse) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (do_reload) begin
        up_ptr_q  <= upbase & C_ALIGN_MASK;
        lp_ptr_q  <= lpbase & C_ALIGN_MASK;
        up_rem_q  <= frame_words;
        lp_rem_q  <= frame_words;
        sel_q     <= 1'b0;
        fp_pend_q <= 1'b0;
      end
    end
  end

`ifdef LCD_DMA_PERF_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of request cycles left waiting for a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (fp_pulse) begin
      stall_cnt_q <= '0;
    end else if ((state_q == ST_REQ) && !m_gnt && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign m_req      = m_req_q;
  assign m_addr     = m_addr_q;
  assign m_len      = m_len_q;
  assign fifo_push  = fifo_push_q;
  assign fifo_data  = fifo_data_q;
  assign busy       = (state_q == ST_REQ) || (state_q == ST_DATA);
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_dma_fetch_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_dma_fetch_engine
// Purpose  : Directed self-checking bench for lcd_dma_fetch_engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_dma_fetch_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, dual_panel, burst_sel;
  logic [31:0] upbase, lpbase;
  logic [15:0] frame_words;
  logic        dma_req, fifofull, fp_pulse;
  logic        m_req;
  logic [31:0] m_addr;
  logic [3:0]  m_len;
  logic        m_gnt, m_rvalid, m_rlast;
  logic [31:0] m_rdata;
  logic        fifo_push;
  logic [31:0] fifo_data;
  logic        busy, frame_done;
`ifdef LCD_DMA_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int push_cnt, fd_cnt, req_cnt;
  logic [31:0] push_log [0:31];

  lcd_dma_fetch_engine #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .dual_panel(dual_panel),
    .burst_sel(burst_sel), .upbase(upbase), .lpbase(lpbase),
    .frame_words(frame_words), .dma_req(dma_req), .fifofull(fifofull),
    .fp_pulse(fp_pulse), .m_req(m_req), .m_addr(m_addr), .m_len(m_len),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .fifo_push(fifo_push), .fifo_data(fifo_data), .busy(busy),
    .frame_done(frame_done)
`ifdef LCD_DMA_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Observe registered outputs mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (fifo_push) begin
      if (push_cnt < 32) push_log[push_cnt] = fifo_data;
      push_cnt = push_cnt + 1;
    end
    if (frame_done) fd_cnt = fd_cnt + 1;
    if (m_req) req_cnt = req_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_fp();
    fp_pulse = 1'b1;
    tick(1);
    fp_pulse = 1'b0;
  endtask

  // Wait for a request, check it, grant after gd cycles, return el beats.
  // fpb selects the beat index that carries an fp_pulse (-1 = none).
  task automatic do_burst(input string tag, input logic [31:0] ea, input int el,
                          input int gd, input int fpb);
    int n;
    n = 0;
    while (!m_req && n < 20) begin
      tick(1);
      n++;
    end
    chk({tag, "_req"}, {63'd0, m_req}, 64'd1);
    chk({tag, "_addr"}, {32'd0, m_addr}, {32'd0, ea});
    chk({tag, "_len"}, {60'd0, m_len}, el);
    tick(gd);
    m_gnt = 1'b1;
    tick(1);
    m_gnt = 1'b0;
    for (int i = 0; i < el; i++) begin
      m_rvalid = 1'b1;
      m_rdata  = ea + 32'(i);
      m_rlast  = (i == el - 1);
      fp_pulse = (i == fpb);
      tick(1);
      fp_pulse = 1'b0;
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; dual_panel = 1'b0; burst_sel = 1'b0;
    upbase = '0; lpbase = '0; frame_words = '0; dma_req = 1'b0;
    fifofull = 1'b0; fp_pulse = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;
    m_rdata = '0; m_rlast = 1'b0;
    push_cnt = 0; fd_cnt = 0; req_cnt = 0;
    tick(3);

    // Reset state.
    chk("rst_m_req", {63'd0, m_req}, 64'd0);
    chk("rst_m_addr", {32'd0, m_addr}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_push", {63'd0, fifo_push}, 64'd0);
    chk("rst_fdone", {63'd0, frame_done}, 64'd0);
    rst = 1'b0;
    tick(3);

    // Single panel, 4-word bursts, 10 words.
    enable = 1'b1; dma_req = 1'b1; upbase = 32'h1000; lpbase = 32'h4000;
    frame_words = 16'd10;
    pulse_fp();
    push_cnt = 0; fd_cnt = 0;
    do_burst("s1", 32'h1000, 4, 1, -1);
    do_burst("s2", 32'h1010, 4, 1, -1);
    do_burst("s3", 32'h1020, 2, 1, -1);
    tick(6);
    chk("single_pushes", push_cnt, 10);
    chk("single_first", {32'd0, push_log[0]}, 64'h1000);
    chk("single_last", {32'd0, push_log[9]}, 64'h1021);
    chk("single_fdone", fd_cnt, 1);
    chk("single_idle_req", {63'd0, m_req}, 64'd0);
    chk("single_busy", {63'd0, busy}, 64'd0);

    // Dual panel, 8-word bursts, 8 words per panel.
    dual_panel = 1'b1; burst_sel = 1'b1; upbase = 32'h2000; lpbase = 32'h8000;
    frame_words = 16'd8;
    pulse_fp();
    push_cnt = 0; fd_cnt = 0;
    do_burst("d1", 32'h2000, 8, 1, -1);
    do_burst("d2", 32'h8000, 8, 1, -1);
    tick(6);
    chk("dual_pushes", push_cnt, 16);
    chk("dual_lower_first", {32'd0, push_log[8]}, 64'h8000);
    chk("dual_fdone", fd_cnt, 1);
    chk("dual_wait_req", {63'd0, m_req}, 64'd0);

    // Frame pulse during the third beat of a 4-beat burst.
    dual_panel = 1'b0; burst_sel = 1'b0; upbase = 32'h1000; frame_words = 16'd10;
    pulse_fp();
    push_cnt = 0; fd_cnt = 0;
    do_burst("f1", 32'h1000, 4, 1, 2);
    tick(1);
    chk("fp_mid_pushes", push_cnt, 4);
    do_burst("f2", 32'h1000, 4, 1, -1);
    do_burst("f3", 32'h1010, 4, 1, -1);
    do_burst("f4", 32'h1020, 2, 1, -1);
    tick(6);
    chk("fp_mid_fdone", fd_cnt, 1);

    // fifofull blocks a new burst; release starts it next cycle.
    fifofull = 1'b1;
    pulse_fp();
    tick(5);
    chk("full_no_req", {63'd0, m_req}, 64'd0);
    chk("full_not_busy", {63'd0, busy}, 64'd0);
    fifofull = 1'b0;
    tick(1);
    chk("full_release_req", {63'd0, m_req}, 64'd1);
    chk("full_release_addr", {32'd0, m_addr}, 64'h1000);

    // Reset in the middle of the data phase.
    m_gnt = 1'b1;
    tick(1);
    m_gnt = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'hAAAA0000;
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("midrst_m_req", {63'd0, m_req}, 64'd0);
    chk("midrst_push", {63'd0, fifo_push}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    push_cnt = 0;
    m_rlast = 1'b1;
    tick(2);
    m_rvalid = 1'b0; m_rlast = 1'b0;
    tick(2);
    chk("midrst_orphan_push", push_cnt, 0);

    // frame_words = 0: frame_done without bus traffic.
    frame_words = 16'd0;
    tick(2);
    req_cnt = 0; fd_cnt = 0;
    pulse_fp();
    tick(4);
    chk("zero_fdone", fd_cnt, 1);
    chk("zero_no_req", req_cnt, 0);

    // Enable dropped mid-burst: burst completes, then no new burst.
    frame_words = 16'd8;
    pulse_fp();
    push_cnt = 0;
    begin : g_en_drop
      int n;
      n = 0;
      while (!m_req && n < 20) begin
        tick(1);
        n++;
      end
    end
    enable = 1'b0;
    do_burst("e1", 32'h1000, 4, 1, -1);
    tick(5);
    chk("endrop_pushes", push_cnt, 4);
    chk("endrop_no_req", {63'd0, m_req}, 64'd0);
    enable = 1'b1;
    do_burst("e2", 32'h1010, 4, 1, -1);
    tick(4);

`ifdef LCD_DMA_PERF_EN
    // Stall counter: five ungranted request cycles, then cleared by a frame pulse.
    frame_words = 16'd4;
    pulse_fp();
    do_burst("p1", 32'h1000, 4, 5, -1);
    tick(3);
    chk("perf_stall", {48'd0, stall_cnt}, 64'd5);
    pulse_fp();
    chk("perf_clear", {48'd0, stall_cnt}, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
